// File: rtl/rsa_modexp_core.sv
// rsa_modexp_core
//   Modular exponentiation a^d mod n for the RSA datapath. Uses right-to-left
//   square-and-multiply where both products of one exponent bit are
//   radix-2 Montgomery products evaluated in parallel, one multiplier bit per
//   cycle. The running product m stays in the plain domain, while the power t
//   is kept in Montgomery form (a*R mod n, R = 2^WIDTH). As a result,
//   MP(m, t) = m*a^(2^k) mod n needs no conversion back out.
//
// Ports
//   avm_clk, avm_rst   clock, asynchronous active-high reset
//   i_start            start request, sampled only while idle
//   i_a, i_d, i_n      base, exponent, modulus (n odd, a < n); captured on start
//   o_a_pow_d          result, held until the next completion
//   o_finished         one-cycle pulse in the cycle o_a_pow_d becomes valid
//   state_dbg          current FSM state (S_IDLE=0 .. S_DONE=4)
//
// Handshake: i_start is a request, not a valid/ready pair. It is accepted
//   only in S_IDLE, and any pulse while busy is dropped. Each accepted
//   request produces exactly one o_finished pulse, (WIDTH+1)^2 cycles after
//   the accepting edge, unless reset intervenes. The cycle after the pulse is
//   idle again, so a new request may be accepted there.
module rsa_modexp_core #(
    parameter int WIDTH = 256
) (
    input  logic             avm_clk,
    input  logic             avm_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_d,
    input  logic [WIDTH-1:0] i_n,
    output logic [WIDTH-1:0] o_a_pow_d,
    output logic             o_finished,
    output logic [2:0]       state_dbg
);

    localparam int KW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PREP   = 3'd1,
        S_MONT   = 3'd2,
        S_UPDATE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r, d_r, n_r;
    logic [WIDTH-1:0] m_r, t_r, b_r;
    logic [WIDTH+1:0] s_mt, s_tt;
    logic [CW-1:0]    cnt;
    logic [KW-1:0]    k;

    logic [WIDTH:0]   t_dbl;
    logic [WIDTH-1:0] prep_next, mt_fin, tt_fin, m_next;

    // One radix-2 Montgomery iteration. If the operands are below n, s stays
    // below x + n < 3n, so WIDTH+2 bits never overflow.
    function automatic logic [WIDTH+1:0] mont_step(
        input logic [WIDTH+1:0] s,
        input logic [WIDTH-1:0] x,
        input logic             bit_j,
        input logic [WIDTH-1:0] n
    );
        logic [WIDTH+1:0] acc;
        acc = s + (bit_j ? {2'b00, x} : '0);
        if (acc[0]) acc = acc + {2'b00, n};
        return acc >> 1;
    endfunction

    // After WIDTH steps s < 2n, so a single conditional subtract reduces it.
    function automatic logic [WIDTH-1:0] mont_final(
        input logic [WIDTH+1:0] s,
        input logic [WIDTH-1:0] n
    );
        return WIDTH'((s >= {2'b00, n}) ? s - {2'b00, n} : s);
    endfunction

    assign t_dbl     = {t_r, 1'b0};
    assign prep_next = WIDTH'((t_dbl >= {1'b0, n_r}) ? t_dbl - {1'b0, n_r} : t_dbl);
    assign mt_fin    = mont_final(s_mt, n_r);
    assign tt_fin    = mont_final(s_tt, n_r);
    assign m_next    = d_r[k] ? mt_fin : m_r;
    assign state_dbg = state;

    always_ff @(posedge avm_clk or posedge avm_rst) begin
        if (avm_rst) begin
            state      <= S_IDLE;
            a_r        <= '0;
            d_r        <= '0;
            n_r        <= '0;
            m_r        <= '0;
            t_r        <= '0;
            b_r        <= '0;
            s_mt       <= '0;
            s_tt       <= '0;
            cnt        <= '0;
            k          <= '0;
            o_a_pow_d  <= '0;
            o_finished <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    o_finished <= 1'b0;
                    if (i_start) begin
                        a_r   <= i_a;
                        d_r   <= i_d;
                        n_r   <= i_n;
                        m_r   <= WIDTH'(1);
                        k     <= '0;
                        cnt   <= '0;
                        state <= S_PREP;
                    end
                end
                // cnt==0 is the load cycle. It is followed by WIDTH modular
                // doublings, which turn a into its Montgomery form a*R mod n.
                S_PREP: begin
                    if (cnt == '0) begin
                        t_r <= a_r;
                        cnt <= cnt + 1'b1;
                    end else begin
                        t_r <= prep_next;
                        if (cnt == CW'(WIDTH)) begin
                            b_r   <= prep_next;
                            s_mt  <= '0;
                            s_tt  <= '0;
                            cnt   <= '0;
                            state <= S_MONT;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                // Both products share the multiplier t. b_r is a copy of t
                // that is shifted right to present bit j in b_r[0].
                S_MONT: begin
                    s_mt <= mont_step(s_mt, m_r, b_r[0], n_r);
                    s_tt <= mont_step(s_tt, t_r, b_r[0], n_r);
                    b_r  <= b_r >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= S_UPDATE;
                end
                S_UPDATE: begin
                    t_r  <= tt_fin;
                    m_r  <= m_next;
                    b_r  <= tt_fin;
                    s_mt <= '0;
                    s_tt <= '0;
                    cnt  <= '0;
                    k    <= k + 1'b1;
                    if (k == KW'(WIDTH - 1)) begin
                        // m only reaches n when it is still the initial 1
                        // and n == 1, and the answer is then 0.
                        o_a_pow_d  <= (m_next >= n_r) ? '0 : m_next;
                        o_finished <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        state <= S_MONT;
                    end
                end
                S_DONE: begin
                    o_finished <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_modexp_core.sv
// tb_rsa_modexp_core
//   Bench for rsa_modexp_core at WIDTH=8 and WIDTH=16. Expected results come
//   from a repeated-multiplication model of a^d mod n. Expected latency is
//   (WIDTH+1)^2 cycles from the edge that samples i_start.
module tb_rsa_modexp_core;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, d8 = '0, n8 = '0;
    logic [7:0]  res8;
    logic        fin8;
    logic [2:0]  st8;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0, d16 = '0, n16 = '0;
    logic [15:0] res16;
    logic        fin16;
    logic [2:0]  st16;

    rsa_modexp_core #(.WIDTH(8)) dut8 (
        .avm_clk   (clk),
        .avm_rst   (rst),
        .i_start   (start8),
        .i_a       (a8),
        .i_d       (d8),
        .i_n       (n8),
        .o_a_pow_d (res8),
        .o_finished(fin8),
        .state_dbg (st8)
    );

    rsa_modexp_core #(.WIDTH(16)) dut16 (
        .avm_clk   (clk),
        .avm_rst   (rst),
        .i_start   (start16),
        .i_a       (a16),
        .i_d       (d16),
        .i_n       (n16),
        .o_a_pow_d (res16),
        .o_finished(fin16),
        .state_dbg (st16)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: a multiplied into an accumulator d times, reduced mod n.
    function automatic longint ref_modexp(input longint a, input longint d, input longint n);
        longint r;
        r = 1 % n;
        for (longint i = 0; i < d; i++) r = (r * a) % n;
        return r;
    endfunction

    function automatic logic obs_fin(input bit wide);
        return wide ? fin16 : fin8;
    endfunction

    // ---------------- driver ----------------
    // Issues one operation. Inputs are scrambled right after the start edge.
    // If pulse_at > 0, a stray start pulse is driven so that it is sampled at
    // that cycle of the run.
    task automatic run_op(input bit wide, input logic [15:0] a, input logic [15:0] d,
                          input logic [15:0] n, input int pulse_at, input string tag);
        int lat;
        int exp_lat;
        logic [63:0] exp;
        exp_lat = wide ? 289 : 81;
        exp_q.push_back(64'(ref_modexp(longint'(a), longint'(d), longint'(n))));
        @(negedge clk);
        if (wide) begin
            start16 = 1'b1; a16 = a; d16 = d; n16 = n;
        end else begin
            start8 = 1'b1; a8 = a[7:0]; d8 = d[7:0]; n8 = n[7:0];
        end
        @(posedge clk); #1;
        start8 = 1'b0; start16 = 1'b0;
        a8 = 8'($urandom); d8 = 8'($urandom); n8 = 8'($urandom);
        a16 = 16'($urandom); d16 = 16'($urandom); n16 = 16'($urandom);
        lat = -1;
        for (int c = 1; c <= 400; c++) begin
            if (wide) start16 = (c == pulse_at);
            else      start8  = (c == pulse_at);
            @(posedge clk); #1;
            if (obs_fin(wide)) begin
                lat = c;
                break;
            end
        end
        start8 = 1'b0; start16 = 1'b0;
        exp = exp_q.pop_front();
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_res"}, wide ? 64'(res16) : 64'(res8), exp);
        @(posedge clk); #1;
        check({tag, "_pulse_width"}, 64'(obs_fin(wide)), 64'(0));
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            if (fin8) pulses++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pulses;
        logic [15:0] n, a, d;

        #22;
        check("reset_res8", 64'(res8), 64'(0));
        check("reset_fin8", 64'(fin8), 64'(0));
        check("reset_state8", 64'(st8), 64'(0));
        check("reset_res16", 64'(res16), 64'(0));
        @(negedge clk); rst = 1'b0;

        run_op(1'b0, 16'd5, 16'd3, 16'd187, 0, "w8_5_3");
        run_op(1'b0, 16'd5, 16'd0, 16'd187, 0, "w8_d0");
        run_op(1'b0, 16'd5, 16'd1, 16'd187, 0, "w8_d1");
        run_op(1'b0, 16'd0, 16'd7, 16'd187, 0, "w8_a0");
        run_op(1'b0, 16'd0, 16'd0, 16'd1,   0, "w8_n1");
        run_op(1'b0, 16'd254, 16'd255, 16'd255, 0, "w8_max");
        run_op(1'b1, 16'd65, 16'd17, 16'd3233, 0, "w16_enc");
        run_op(1'b1, 16'd2790, 16'd413, 16'd3233, 0, "w16_dec");

        // A stray start pulse mid-run must not restart or add a pulse.
        run_op(1'b0, 16'd5, 16'd3, 16'd187, 40, "w8_stray");
        count_pulses(100, pulses);
        check("stray_extra_pulses", 64'(pulses), 64'(0));

        // A reset mid-run aborts the operation without a pulse.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'd5; d8 = 8'd3; n8 = 8'd187;
        @(posedge clk); #1; start8 = 1'b0;
        repeat (39) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_state", 64'(st8), 64'(0));
        check("abort_res", 64'(res8), 64'(0));
        check("abort_fin", 64'(fin8), 64'(0));
        @(negedge clk); rst = 1'b0;
        count_pulses(100, pulses);
        check("abort_no_pulse", 64'(pulses), 64'(0));
        run_op(1'b0, 16'd7, 16'd5, 16'd187, 0, "w8_after_abort");

        // Randomized back-to-back runs.
        for (int i = 0; i < 20; i++) begin
            n = 16'($urandom_range(1, 127) * 2 + 1);
            a = 16'($urandom_range(0, int'(n) - 1));
            d = 16'($urandom_range(0, 255));
            run_op(1'b0, a, d, n, 0, $sformatf("w8_rand%0d", i));
        end
        for (int i = 0; i < 8; i++) begin
            n = 16'($urandom_range(1, 32767) * 2 + 1);
            a = 16'($urandom_range(0, int'(n) - 1));
            d = 16'($urandom_range(0, 65535));
            run_op(1'b1, a, d, n, 0, $sformatf("w16_rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
